// File: rtl/cache_data_assoc_if.sv
// CPU access and line-refill signal bundle for cache_data_assoc.
// slave = data array side, master = cache controller / refill logic side.
interface cache_data_assoc_if #(
    parameter int WAY_BIT    = 1,
    parameter int BLKIDX_BIT = 4,
    parameter int WRDIDX_BIT = 4,
    parameter int DATA_W     = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [WAY_BIT-1:0]    req_way;
    logic [BLKIDX_BIT-1:0] req_blkidx;
    logic [WRDIDX_BIT-1:0] req_wrdidx;
    logic [BE_W-1:0]       req_wen;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;

    logic                  fill_start;
    logic [WAY_BIT-1:0]    fill_way;
    logic [BLKIDX_BIT-1:0] fill_blkidx;
    logic                  fill_valid;
    logic [DATA_W-1:0]     fill_data;
    logic                  fill_ready;
    logic                  fill_busy;
    logic                  fill_done;

    modport slave (
        input  req_valid, req_way, req_blkidx, req_wrdidx, req_wen, req_wdata,
        output req_ready, rdata, rvalid,
        input  fill_start, fill_way, fill_blkidx, fill_valid, fill_data,
        output fill_ready, fill_busy, fill_done
    );

    modport master (
        output req_valid, req_way, req_blkidx, req_wrdidx, req_wen, req_wdata,
        input  req_ready, rdata, rvalid,
        output fill_start, fill_way, fill_blkidx, fill_valid, fill_data,
        input  fill_ready, fill_busy, fill_done
    );
endinterface

// File: rtl/cache_data_assoc.sv
// Set-associative cache data array: byte-enable CPU port with registered read plus a line refill engine.
// Define CACHE_DATA_FWD_EN to return the merged post-write word on read+write accesses.
//
// state  | meaning
// S_IDLE | CPU port open, waiting for fill_start
// S_FILL | accepting refill words into the latched way/block
// S_DONE | last word written, fill_done pulse, CPU port still closed
module cache_data_assoc #(
    parameter int WAY_BIT    = 1,
    parameter int BLKIDX_BIT = 4,
    parameter int WRDIDX_BIT = 4,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_data_assoc_if.slave    bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int ADDR_W = WAY_BIT + BLKIDX_BIT + WRDIDX_BIT;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAY_BIT-1:0]    r_fill_way;
    logic [WAY_BIT-1:0]    w_fill_way_nxt;
    logic [BLKIDX_BIT-1:0] r_fill_blk;
    logic [BLKIDX_BIT-1:0] w_fill_blk_nxt;
    logic [WRDIDX_BIT-1:0] r_wrd_cnt;
    logic [WRDIDX_BIT-1:0] w_wrd_cnt_nxt;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rvalid;

    logic                  w_cpu_acc;
    logic                  w_fill_beat;
    logic [ADDR_W-1:0]     w_cpu_addr;
    logic [ADDR_W-1:0]     w_fill_addr;
    logic [DATA_W-1:0]     w_old;
    logic [DATA_W-1:0]     w_merged;
    logic [DATA_W-1:0]     w_rd_sel;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.fill_ready = (r_state == S_FILL);
    assign bus.fill_busy  = (r_state == S_FILL);
    assign bus.fill_done  = (r_state == S_DONE);
    assign bus.rdata      = r_rdata;
    assign bus.rvalid     = r_rvalid;

    assign w_cpu_acc   = bus.req_valid && bus.req_ready;
    assign w_fill_beat = bus.fill_valid && bus.fill_ready;
    assign w_cpu_addr  = {bus.req_way, bus.req_blkidx, bus.req_wrdidx};
    assign w_fill_addr = {r_fill_way, r_fill_blk, r_wrd_cnt};
    assign w_old       = r_mem[w_cpu_addr];

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < BE_W; b++) begin
            if (bus.req_wen[b]) begin
                w_merged[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
            end
        end
    end

`ifdef CACHE_DATA_FWD_EN
    assign w_rd_sel = w_merged;
`else
    assign w_rd_sel = w_old;
`endif

    // CPU writes only happen in IDLE and refill beats only in FILL, so one write port suffices.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_cpu_addr;
        w_mem_wdata = w_merged;
        if (w_fill_beat) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_fill_addr;
            w_mem_wdata = bus.fill_data;
        end else if (w_cpu_acc && (bus.req_wen != '0)) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_cpu_acc;
            if (w_cpu_acc) begin
                r_rdata <= w_rd_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fill_way <= '0;
            r_fill_blk <= '0;
            r_wrd_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_way <= w_fill_way_nxt;
            r_fill_blk <= w_fill_blk_nxt;
            r_wrd_cnt  <= w_wrd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_way_nxt = r_fill_way;
        w_fill_blk_nxt = r_fill_blk;
        w_wrd_cnt_nxt  = r_wrd_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.fill_start) begin
                    w_state_nxt    = S_FILL;
                    w_fill_way_nxt = bus.fill_way;
                    w_fill_blk_nxt = bus.fill_blkidx;
                    w_wrd_cnt_nxt  = '0;
                end
            end
            S_FILL: begin
                if (w_fill_beat) begin
                    // Counter wraps to 0 on the last word, ready for the next line.
                    w_wrd_cnt_nxt = r_wrd_cnt + 1'b1;
                    if (r_wrd_cnt == {WRDIDX_BIT{1'b1}}) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_data_assoc.sv
// Directed testbench for cache_data_assoc; expected values are hand-computed.
// Honours CACHE_DATA_FWD_EN to select the forwarding expectation.
module tb_cache_data_assoc;
`ifdef CACHE_DATA_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   done_cnt;

    cache_data_assoc_if #(.WAY_BIT(1), .BLKIDX_BIT(4), .WRDIDX_BIT(4), .DATA_W(32)) bus ();

    cache_data_assoc #(.WAY_BIT(1), .BLKIDX_BIT(4), .WRDIDX_BIT(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fill_done) done_cnt++;
    end

    // One CPU access: drive on a falling edge, return what is visible one cycle later.
    task automatic access(input logic w, input logic [3:0] b, input logic [3:0] d,
                          input logic [3:0] wen, input logic [31:0] wdata,
                          output logic rv, output logic [31:0] rd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_way    = w;
        bus.req_blkidx = b;
        bus.req_wrdidx = d;
        bus.req_wen    = wen;
        bus.req_wdata  = wdata;
        @(negedge clk);
        rv = bus.rvalid;
        rd = bus.rdata;
        bus.req_valid = 1'b0;
        bus.req_wen   = 4'h0;
    endtask

    task automatic start_fill(input logic w, input logic [3:0] b);
        @(negedge clk);
        bus.fill_start  = 1'b1;
        bus.fill_way    = w;
        bus.fill_blkidx = b;
        @(negedge clk);
        bus.fill_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want %h", bus.rdata, 32'h0); end
        n_vec++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_vec++; if ({bus.fill_ready, bus.fill_busy, bus.fill_done} !== 3'b000) begin n_err++; $display("FAIL reset_fill got %b want 000", {bus.fill_ready, bus.fill_busy, bus.fill_done}); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_write_read;
        logic rv; logic [31:0] rd;
        access(1'b1, 4'd3, 4'd5, 4'hF, 32'hDEADBEEF, rv, rd);
        n_vec++; if (rv !== 1'b1) begin n_err++; $display("FAIL wr_rvalid got %b want 1", rv); end
        access(1'b1, 4'd3, 4'd5, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_deadbeef got %h want %h", rd, 32'hDEADBEEF); end
        access(1'b1, 4'd3, 4'd5, 4'hF, 32'h12345678, rv, rd);
        n_vec++; if (rd !== (FWD ? 32'h12345678 : 32'hDEADBEEF)) begin n_err++; $display("FAIL rbw got %h want %h", rd, FWD ? 32'h12345678 : 32'hDEADBEEF); end
        @(negedge clk);
        n_vec++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid got %b want 0", bus.rvalid); end
        n_vec++; if (bus.rdata !== rd) begin n_err++; $display("FAIL idle_rdata_hold got %h want %h", bus.rdata, rd); end
        access(1'b1, 4'd3, 4'd5, 4'h0, 32'hFFFFFFFF, rv, rd);
        n_vec++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL rd_overwrite got %h want %h", rd, 32'h12345678); end
    endtask

    task automatic test_partial;
        logic rv; logic [31:0] rd;
        access(1'b0, 4'd1, 4'd2, 4'hF, 32'h11223344, rv, rd);
        access(1'b0, 4'd1, 4'd2, 4'b0101, 32'hAABBCCDD, rv, rd);
        n_vec++; if (rd !== (FWD ? 32'h11BB33DD : 32'h11223344)) begin n_err++; $display("FAIL partial_acc got %h want %h", rd, FWD ? 32'h11BB33DD : 32'h11223344); end
        access(1'b0, 4'd1, 4'd2, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL partial_rd got %h want %h", rd, 32'h11BB33DD); end
    endtask

    task automatic test_refill;
        logic rv; logic [31:0] rd;
        done_cnt = 0;
        start_fill(1'b0, 4'd2);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                for (int s = 0; s < 3; s++) begin
                    bus.fill_valid = 1'b0;
                    @(negedge clk);
                    n_vec++; if ({bus.fill_busy, bus.req_ready} !== 2'b10) begin n_err++; $display("FAIL stall_state got %b want 10", {bus.fill_busy, bus.req_ready}); end
                end
            end
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h100 + i;
            n_vec++; if ({bus.fill_ready, bus.req_ready} !== 2'b10) begin n_err++; $display("FAIL fill_ready beat %0d got %b want 10", i, {bus.fill_ready, bus.req_ready}); end
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        n_vec++; if ({bus.fill_done, bus.fill_busy, bus.fill_ready, bus.req_ready} !== 4'b1000) begin n_err++; $display("FAIL done_state got %b want 1000", {bus.fill_done, bus.fill_busy, bus.fill_ready, bus.req_ready}); end
        @(negedge clk);
        n_vec++; if ({bus.fill_done, bus.req_ready} !== 2'b01) begin n_err++; $display("FAIL post_done got %b want 01", {bus.fill_done, bus.req_ready}); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL done_pulses got %0d want 1", done_cnt); end
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 4'd2, 4'(i), 4'h0, 32'h0, rv, rd);
            n_vec++; if (rd !== 32'h100 + i) begin n_err++; $display("FAIL refill_wrd%0d got %h want %h", i, rd, 32'h100 + i); end
        end
    endtask

    task automatic test_start_with_req;
        logic rv; logic [31:0] rd;
        access(1'b1, 4'd0, 4'd0, 4'hF, 32'h00000055, rv, rd);
        done_cnt = 0;
        @(negedge clk);
        bus.fill_start  = 1'b1;
        bus.fill_way    = 1'b1;
        bus.fill_blkidx = 4'd4;
        bus.req_valid   = 1'b1;
        bus.req_way     = 1'b1;
        bus.req_blkidx  = 4'd0;
        bus.req_wrdidx  = 4'd0;
        bus.req_wen     = 4'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_vec++; if (bus.rvalid !== 1'b1) begin n_err++; $display("FAIL concur_rvalid got %b want 1", bus.rvalid); end
        n_vec++; if (bus.rdata !== 32'h55) begin n_err++; $display("FAIL concur_rdata got %h want %h", bus.rdata, 32'h55); end
        n_vec++; if (bus.fill_busy !== 1'b1) begin n_err++; $display("FAIL concur_busy got %b want 1", bus.fill_busy); end
        bus.fill_way    = 1'b0;
        bus.fill_blkidx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            bus.fill_start = (i < 2);
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h200 + i;
            @(negedge clk);
        end
        bus.fill_start = 1'b0;
        bus.fill_data  = 32'hBAD0BAD0;
        n_vec++; if ({bus.fill_done, bus.fill_ready} !== 2'b10) begin n_err++; $display("FAIL concur_done got %b want 10", {bus.fill_done, bus.fill_ready}); end
        @(negedge clk);
        bus.fill_valid = 1'b0;
        n_vec++; if ({bus.fill_busy, bus.req_ready} !== 2'b01) begin n_err++; $display("FAIL concur_idle got %b want 01", {bus.fill_busy, bus.req_ready}); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL concur_pulses got %0d want 1", done_cnt); end
        access(1'b1, 4'd4, 4'd0, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h200) begin n_err++; $display("FAIL concur_wrd0 got %h want %h", rd, 32'h200); end
        access(1'b1, 4'd4, 4'd15, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h20F) begin n_err++; $display("FAIL concur_wrd15 got %h want %h", rd, 32'h20F); end
    endtask

    task automatic test_reset_mid_fill;
        logic rv; logic [31:0] rd;
        access(1'b1, 4'd6, 4'd0, 4'h0, 32'h0, rv, rd);
        start_fill(1'b1, 4'd6);
        for (int i = 0; i < 7; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h300 + i;
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if ({bus.fill_ready, bus.fill_busy, bus.fill_done, bus.rvalid} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctl got %b want 0000", {bus.fill_ready, bus.fill_busy, bus.fill_done, bus.rvalid}); end
        n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata got %h want 0", bus.rdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            access(1'b1, 4'd6, 4'(i), 4'h0, 32'h0, rv, rd);
            n_vec++; if (rd !== 32'h300 + i) begin n_err++; $display("FAIL partial_line_wrd%0d got %h want %h", i, rd, 32'h300 + i); end
        end
        start_fill(1'b1, 4'd6);
        for (int i = 0; i < 16; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = 32'h400 + i;
            @(negedge clk);
        end
        bus.fill_valid = 1'b0;
        @(negedge clk);
        access(1'b1, 4'd6, 4'd0, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h400) begin n_err++; $display("FAIL restart_wrd0 got %h want %h", rd, 32'h400); end
        access(1'b1, 4'd6, 4'd7, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h407) begin n_err++; $display("FAIL restart_wrd7 got %h want %h", rd, 32'h407); end
        access(1'b1, 4'd6, 4'd15, 4'h0, 32'h0, rv, rd);
        n_vec++; if (rd !== 32'h40F) begin n_err++; $display("FAIL restart_wrd15 got %h want %h", rd, 32'h40F); end
    endtask

    task automatic test_forwarding;
        logic rv; logic [31:0] rd;
        access(1'b0, 4'd9, 4'd1, 4'hF, 32'h0, rv, rd);
        access(1'b0, 4'd9, 4'd1, 4'hF, 32'hCAFEF00D, rv, rd);
        n_vec++; if (rd !== (FWD ? 32'hCAFEF00D : 32'h0)) begin n_err++; $display("FAIL fwd_full got %h want %h", rd, FWD ? 32'hCAFEF00D : 32'h0); end
        access(1'b0, 4'd9, 4'd1, 4'b1000, 32'h12000000, rv, rd);
        n_vec++; if (rd !== (FWD ? 32'h12FEF00D : 32'hCAFEF00D)) begin n_err++; $display("FAIL fwd_byte got %h want %h", rd, FWD ? 32'h12FEF00D : 32'hCAFEF00D); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        done_cnt = 0;
        rst = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_way     = '0;
        bus.req_blkidx  = '0;
        bus.req_wrdidx  = '0;
        bus.req_wen     = '0;
        bus.req_wdata   = '0;
        bus.fill_start  = 1'b0;
        bus.fill_way    = '0;
        bus.fill_blkidx = '0;
        bus.fill_valid  = 1'b0;
        bus.fill_data   = '0;
        test_reset();
        test_write_read();
        test_partial();
        test_refill();
        test_start_with_req();
        test_reset_mid_fill();
        test_forwarding();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cache_data_assoc.md
Name: cache_data_assoc

Overview:
Set-associative data storage for the L1 caches: WAY_NUM ways × BLK_NUM blocks × WRD_NUM words, each DATA_W wide. It has a single-port CPU access path with byte-enable writes and a registered (1-cycle) read. A refill engine writes a whole line from the memory side, word by word, under a valid/ready handshake. It sits between the cache controller (tag compare, way select) and the bus refill logic.

Parameters:
WAY_BIT, 1, log2 of the number of ways (WAY_NUM = 1<<WAY_BIT).
BLKIDX_BIT, 4, block index width (BLK_NUM = 1<<BLKIDX_BIT).
WRDIDX_BIT, 4, word index width (WRD_NUM = 1<<WRDIDX_BIT).
DATA_W, 32, word width in bits; must be a multiple of 8 (BE_W = DATA_W/8).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  CPU access request
req_ready  out  1  array can accept a CPU access this cycle
req_way  in  WAY_BIT  way to access
req_blkidx  in  BLKIDX_BIT  block index
req_wrdidx  in  WRDIDX_BIT  word index
req_wen  in  BE_W  byte write enables; all-zero means read only
req_wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, registered
rvalid  out  1  rdata holds the result of the request accepted last cycle
fill_start  in  1  start a line refill (one-cycle pulse)
fill_way  in  WAY_BIT  destination way, sampled on fill_start
fill_blkidx  in  BLKIDX_BIT  destination block, sampled on fill_start
fill_valid  in  1  fill_data holds a word
fill_data  in  DATA_W  refill word, delivered in order from word 0 upward
fill_ready  out  1  engine accepts fill_data this cycle
fill_busy  out  1  refill in progress
fill_done  out  1  one-cycle pulse when the last word has been written

Behaviour:
- Reset (asynchronous): rdata=0, rvalid=0, fill_ready=0, fill_busy=0, fill_done=0, FSM=IDLE, word counter=0. Storage contents are not cleared and are undefined after power-up.
- CPU accept condition: req_valid && req_ready. req_ready = (FSM==IDLE).
- On accept, the selected word is read. If req_wen≠0, each byte i whose req_wen[i]=1 is replaced by req_wdata byte i on the same edge; other bytes are unchanged.
- rdata/rvalid latency: valid 1 cycle after accept. rdata holds the pre-write value (read-before-write). rvalid=0 in cycles after a non-accept; rdata holds its last value.
- FSM IDLE:
  - fill_start → FILL. Latch fill_way and fill_blkidx, counter=0.
  - A CPU request in the same cycle as fill_start is still accepted, since req_ready depends on the current state.
- FSM FILL:
  - fill_ready=1 and fill_busy=1; req_ready=0.
  - Each fill_valid && fill_ready beat writes the full word to [way][blk][counter], then counter+1.
  - The beat with counter==WRD_NUM-1 moves the FSM to DONE; the counter wraps to 0.
  - fill_valid low stalls the engine indefinitely with no timeout.
  - fill_start while in FILL is ignored.
- FSM DONE: fill_done=1 for exactly one cycle, fill_busy=0, fill_ready=0, then → IDLE. req_ready is 0 in DONE.
- Reset mid-fill: FSM returns to IDLE immediately. Words already written stay written; the line is partial, and the controller must not mark it valid.
- Indices are always in range by construction, since widths equal log2 of depth.

Optional Feature:
- Macro name: CACHE_DATA_FWD_EN.
- Defined: rdata after a read+write accept returns the merged post-write word (write-forwarding). This applies in the same case where the default returns the old word.
- Not defined: read-before-write as stated above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write way1 blk3 wrd5 = 0xDEADBEEF with wen=4'hF, then read the same word → the accept cycle gives rvalid=1 next cycle, rdata=old value. The following read returns 0xDEADBEEF.
- Partial write: 0x11223344 stored, then wen=4'b0101 with wdata=0xAABBCCDD → a later read returns 0x11BB33DD.
- Refill: fill_start way0 blk2, then 16 beats of data 0x100+i with fill_valid dropped for 3 cycles mid-burst → fill_done pulses once, 1 cycle after beat 15. Reads of wrd0..15 return 0x100..0x10F. req_ready=0 throughout FILL and DONE.
- fill_start and req_valid in the same IDLE cycle → the request is accepted and rvalid appears next cycle; FILL begins, and a second fill_start during FILL is ignored (only 16 beats are consumed).
- Assert rst after 7 refill beats → all outputs return to reset values immediately. Words 0..6 hold the fill data; a new fill_start restarts the counter at 0.
- With CACHE_DATA_FWD_EN: write 0xCAFEF00D over 0x0 → rdata on the same access's rvalid is 0xCAFEF00D. Without the macro it is 0x0.
